// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, taken-branch kill and mul/div sequencing.
// Define HAZ_PERF_EN to add the perf_stall_cnt / perf_flush_cnt / perf_md_cnt counters.
module hazard_ctrl #(
    parameter int unsigned REG_IDX_W  = 5,
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] D_rs1_index,
    input  logic [REG_IDX_W-1:0] D_rs2_index,
    input  logic                 D_uses_rs1,
    input  logic                 D_uses_rs2,
    input  logic [REG_IDX_W-1:0] E_rd_index,
    input  logic                 E_is_load,
    input  logic                 E_is_md,
    input  logic                 E_branch_taken,
    input  logic                 md_done,
    output logic                 stall_pc,
    output logic                 stall_F_D,
    output logic                 stall_D_E,
    output logic                 flush_F_D,
    output logic                 flush_D_E,
    output logic                 md_start,
    output logic                 md_err,
    output logic                 busy
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_flush_cnt,
    output logic [31:0]          perf_md_cnt
`endif
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             md_err_q;
    logic             load_use;
    logic             timeout;

    always_comb begin
        load_use = E_is_load && (E_rd_index != '0) &&
                   ((D_uses_rs1 && (D_rs1_index == E_rd_index)) ||
                    (D_uses_rs2 && (D_rs2_index == E_rd_index)));
        timeout  = (wait_cnt == CNT_W'(MD_TIMEOUT)) && !md_done;
    end

    // Outputs are decoded from state and inputs; gating with rst_n keeps them 0 during reset.
    always_comb begin
        stall_pc  = 1'b0;
        stall_F_D = 1'b0;
        stall_D_E = 1'b0;
        flush_F_D = 1'b0;
        flush_D_E = 1'b0;
        md_start  = 1'b0;
        busy      = 1'b0;
        md_err    = md_err_q;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (E_branch_taken) begin
                        flush_F_D = 1'b1;
                        flush_D_E = 1'b1;
                    end else if (E_is_md) begin
                        md_start  = 1'b1;
                        stall_pc  = 1'b1;
                        stall_F_D = 1'b1;
                        stall_D_E = 1'b1;
                    end else if (load_use) begin
                        stall_pc  = 1'b1;
                        stall_F_D = 1'b1;
                        flush_D_E = 1'b1;
                    end
                end
                MD_WAIT: begin
                    busy = 1'b1;
                    if (!md_done && !timeout) begin
                        stall_pc  = 1'b1;
                        stall_F_D = 1'b1;
                        stall_D_E = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            md_err_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!E_branch_taken && E_is_md) begin
                        state    <= MD_WAIT;
                        wait_cnt <= CNT_W'(1);
                    end
                end
                MD_WAIT: begin
                    if (md_done) begin
                        state <= RUN;
                    end else if (timeout) begin
                        state    <= RUN;
                        md_err_q <= 1'b1;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
            perf_md_cnt    <= '0;
        end else begin
            if (stall_pc)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush_F_D) perf_flush_cnt <= perf_flush_cnt + 32'd1;
            if (md_start)  perf_md_cnt    <= perf_md_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MD_TIMEOUT overridden to 8).
// Output vector order: {stall_pc, stall_F_D, stall_D_E, flush_F_D, flush_D_E, md_start, md_err, busy}.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] D_rs1_index, D_rs2_index, E_rd_index;
    logic       D_uses_rs1, D_uses_rs2;
    logic       E_is_load, E_is_md, E_branch_taken, md_done;
    logic       stall_pc, stall_F_D, stall_D_E, flush_F_D, flush_D_E;
    logic       md_start, md_err, busy;
`ifdef HAZ_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_md_cnt;
`endif

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  got;

    hazard_ctrl #(
        .REG_IDX_W (5),
        .MD_TIMEOUT(8),
        .CNT_W     (7)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .D_rs1_index   (D_rs1_index),
        .D_rs2_index   (D_rs2_index),
        .D_uses_rs1    (D_uses_rs1),
        .D_uses_rs2    (D_uses_rs2),
        .E_rd_index    (E_rd_index),
        .E_is_load     (E_is_load),
        .E_is_md       (E_is_md),
        .E_branch_taken(E_branch_taken),
        .md_done       (md_done),
        .stall_pc      (stall_pc),
        .stall_F_D     (stall_F_D),
        .stall_D_E     (stall_D_E),
        .flush_F_D     (flush_F_D),
        .flush_D_E     (flush_D_E),
        .md_start      (md_start),
        .md_err        (md_err),
        .busy          (busy)
`ifdef HAZ_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt),
        .perf_md_cnt   (perf_md_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        #1;
        got = {stall_pc, stall_F_D, stall_D_E, flush_F_D, flush_D_E, md_start, md_err, busy};
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

`ifdef HAZ_PERF_EN
    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
`endif

    task automatic clear_inputs();
        D_rs1_index = '0; D_rs2_index = '0; E_rd_index = '0;
        D_uses_rs1 = 1'b0; D_uses_rs2 = 1'b0;
        E_is_load = 1'b0; E_is_md = 1'b0; E_branch_taken = 1'b0; md_done = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        E_branch_taken = 1'b1;
        #2;
        chk("reset_outputs", 8'b0000_0000);
        #10;
        E_branch_taken = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("idle_run", 8'b0000_0000);

        // Load-use on rs1, then clears once the load advances
        E_is_load = 1'b1; E_rd_index = 5'd5; D_uses_rs1 = 1'b1; D_rs1_index = 5'd5;
        chk("load_use_rs1", 8'b1100_1000);
        tick();
        clear_inputs();
        chk("load_use_after", 8'b0000_0000);
        tick();
        E_is_load = 1'b1; E_rd_index = 5'd7; D_uses_rs2 = 1'b1; D_rs2_index = 5'd7;
        chk("load_use_rs2", 8'b1100_1000);
        tick();
        clear_inputs();
        E_is_load = 1'b1; E_rd_index = 5'd9; D_uses_rs1 = 1'b0; D_rs1_index = 5'd9;
        chk("rs1_not_used", 8'b0000_0000);
        tick();
        E_is_load = 1'b1; E_rd_index = 5'd0; D_uses_rs1 = 1'b1; D_rs1_index = 5'd0;
        chk("rd_x0_no_hazard", 8'b0000_0000);
        tick();

        // Branch beats a concurrent load-use
        E_is_load = 1'b1; E_rd_index = 5'd5; D_uses_rs1 = 1'b1; D_rs1_index = 5'd5;
        E_branch_taken = 1'b1;
        chk("branch_wins", 8'b0001_1000);
        tick();
        clear_inputs();

        // Mul/div with md_done 4 cycles after start; hazards ignored while waiting
        E_is_md = 1'b1;
        chk("md_start_cycle", 8'b1110_0100);
        tick();
        for (int i = 1; i <= 3; i++) begin
            E_branch_taken = (i == 2);
            E_is_load = 1'b1; E_rd_index = 5'd3; D_uses_rs1 = 1'b1; D_rs1_index = 5'd3;
            chk("md_wait", 8'b1110_0001);
            tick();
        end
        E_branch_taken = 1'b0; E_is_load = 1'b0;
        md_done = 1'b1;
        chk("md_done_release", 8'b0000_0001);
        tick();
        clear_inputs();
        chk("md_back_run", 8'b0000_0000);
        tick();

        // md_done coincident with timeout: done wins, no error
        E_is_md = 1'b1;
        chk("md2_start", 8'b1110_0100);
        tick();
        for (int i = 1; i <= 7; i++) tick();
        md_done = 1'b1;
        chk("done_at_timeout", 8'b0000_0001);
        tick();
        clear_inputs();
        chk("done_beats_timeout", 8'b0000_0000);
        tick();

        // Timeout after 8 MD_WAIT cycles
        E_is_md = 1'b1;
        chk("md3_start", 8'b1110_0100);
        tick();
        for (int i = 1; i <= 7; i++) begin
            if (i == 7) chk("md3_wait7", 8'b1110_0001);
            tick();
        end
        chk("timeout_release", 8'b0000_0001);
        tick();
        E_is_md = 1'b0;
        chk("md_err_set", 8'b0000_0010);
        tick();
        E_is_load = 1'b1; E_rd_index = 5'd4; D_uses_rs2 = 1'b1; D_rs2_index = 5'd4;
        chk("md_err_sticky", 8'b1100_1010);
        tick();
        clear_inputs();

        // Reset on the 3rd MD_WAIT cycle
        E_is_md = 1'b1;
        tick();
        tick();
        tick();
        chk("md4_wait3", 8'b1110_0011);
        rst_n = 1'b0;
        chk("reset_mid_wait", 8'b0000_0000);
        tick();
        E_is_md = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("after_reset_run", 8'b0000_0000);
        tick();
        chk("after_reset_idle", 8'b0000_0000);

`ifdef HAZ_PERF_EN
        // Fresh counters: one mul/div (md_done 4 cycles after start) then one branch
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        E_is_md = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) tick();
        md_done = 1'b1;
        tick();
        clear_inputs();
        E_branch_taken = 1'b1;
        tick();
        clear_inputs();
        tick();
        chk32("perf_md_cnt", perf_md_cnt, 32'd1);
        chk32("perf_stall_cnt", perf_stall_cnt, 32'd4);
        chk32("perf_flush_cnt", perf_flush_cnt, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
